// File: rtl/boreal_tvns_multichan_stim.sv
// boreal_tvns_multichan_stim
//   N-channel charge-balanced biphasic tVNS burst engine. Each channel runs an
//   independent burst FSM (cathodic phase, interphase gap, anodic phase, rest),
//   a leaky-bucket duty interlock and a post-burst refractory lockout. The
//   cardiac T-wave inhibit, AD-Guard intensity clamp and abort are shared.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   trig[N_CH]       per-channel burst request, level, sampled every clk
//   intensity[8*N]   per-channel phase width in us, channel k = [8k+7:8k]
//   t_wave_inhibit   cardiac vulnerable-window flag, sampled at slot start
//   ad_guard_active  clamps the latched width to AD_MAX_INT
//   abort            global stop request
//   stim_cath[N]     cathodic phase drive (registered)
//   stim_anod[N]     anodic phase drive (registered)
//   burst_busy[N]    channel not idle, refractory included (registered)
//   safety_active[N] bucket at or above BUDGET_CYC (decoded from bucket register)
//   trig_drop[N]     trig seen and not accepted (registered, one cycle per trig cycle)
//   pulse_skip[N]    slot suppressed by t_wave_inhibit (registered strobe)
module boreal_tvns_multichan_stim #(
    parameter int N_CH         = 2,
    parameter int CYC_PER_US   = 100,
    parameter int PERIOD_CYC   = 4_000_000,
    parameter int BURST_PULSES = 15,
    parameter int IPG_CYC      = 1_000,
    parameter int BUDGET_CYC   = 100_000_000,
    parameter int REFRACT_CYC  = 1_000_000,
    parameter int AD_MAX_INT   = 64,
    // Ceiling on the accepted width outside AD-Guard mode; 255 is the full
    // 8-bit range. The period check below is made against this ceiling.
    parameter int INT_MAX      = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   trig,
    input  logic [8*N_CH-1:0] intensity,
    input  logic              t_wave_inhibit,
    input  logic              ad_guard_active,
    input  logic              abort,
    output logic [N_CH-1:0]   stim_cath,
    output logic [N_CH-1:0]   stim_anod,
    output logic [N_CH-1:0]   burst_busy,
    output logic [N_CH-1:0]   safety_active,
    output logic [N_CH-1:0]   trig_drop,
    output logic [N_CH-1:0]   pulse_skip
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CATH = 3'd1,
        ST_GAP  = 3'd2,
        ST_ANOD = 3'd3,
        ST_REST = 3'd4,
        ST_COOL = 3'd5
    } state_t;

    localparam int SLOT_W = (BURST_PULSES > 1) ? $clog2(BURST_PULSES) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BURST_PULSES - 1);
    localparam logic [31:0] PERIOD_L  = 32'(PERIOD_CYC);
    localparam logic [31:0] IPG_L     = 32'(IPG_CYC);
    localparam logic [31:0] BUDGET_L  = 32'(BUDGET_CYC);
    localparam logic [31:0] REFRACT_L = 32'(REFRACT_CYC);
    localparam logic [31:0] CPU_L     = 32'(CYC_PER_US);
    localparam logic [7:0]  AD_CEIL   = 8'(AD_MAX_INT);
    localparam logic [7:0]  INT_CEIL  = 8'(INT_MAX);

    // The widest biphasic pulse must leave at least one REST cycle per slot,
    // otherwise slot starts would drift and charge balance could be cut short.
    if ((2 * INT_MAX * CYC_PER_US + IPG_CYC >= PERIOD_CYC) || (IPG_CYC < 1) ||
        (REFRACT_CYC < 1) || (CYC_PER_US < 1)) begin : g_bad_timing
        $error("boreal_tvns_multichan_stim: pulse timing does not fit the period");
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t            state_r, state_nx;
        logic [31:0]       cnt_r, cnt_nx;
        logic [31:0]       bucket_r, bucket_nx;
        logic [SLOT_W-1:0] slot_r, slot_nx;
        logic [7:0]        w_r, w_nx, w_in_s, ceil_s;
        logic              stop_r, stop_nx;
        logic              drop_nx, skip_nx;
        logic              cath_r, anod_r, busy_r, drop_r, skip_r;
        logic              safety_s, stop_s;
        logic [31:0]       hw_s, cath_last_s, gap_last_s, anod_last_s;

        assign ceil_s      = ad_guard_active ? AD_CEIL : INT_CEIL;
        assign w_in_s      = (intensity[8*k +: 8] > ceil_s) ? ceil_s : intensity[8*k +: 8];
        assign safety_s    = (bucket_r >= BUDGET_L);
        assign stop_s      = abort | safety_s;
        // cnt_r counts from 0 at each slot start, so phase boundaries are
        // fixed offsets into the slot.
        assign hw_s        = 32'(w_r) * CPU_L;
        assign cath_last_s = hw_s - 32'd1;
        assign gap_last_s  = hw_s + IPG_L - 32'd1;
        assign anod_last_s = hw_s + hw_s + IPG_L - 32'd1;

        // Burst FSM next-state, slot bookkeeping and drop/skip strobes.
        always_comb begin
            state_nx = state_r;
            cnt_nx   = cnt_r;
            slot_nx  = slot_r;
            w_nx     = w_r;
            stop_nx  = stop_r;
            drop_nx  = 1'b0;
            skip_nx  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trig[k]) begin
                        if (!safety_s && !abort && (w_in_s != 8'd0)) begin
                            w_nx    = w_in_s;
                            slot_nx = '0;
                            cnt_nx  = 32'd0;
                            stop_nx = 1'b0;
                            if (t_wave_inhibit) begin
                                state_nx = ST_REST;
                                skip_nx  = 1'b1;
                            end else begin
                                state_nx = ST_CATH;
                            end
                        end else begin
                            drop_nx = 1'b1;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_CATH: begin
                    drop_nx = trig[k];
                    cnt_nx  = cnt_r + 32'd1;
                    stop_nx = stop_r | stop_s;
                    if (cnt_r == cath_last_s) begin
                        state_nx = ST_GAP;
                    end else begin
                        state_nx = ST_CATH;
                    end
                end
                ST_GAP: begin
                    drop_nx = trig[k];
                    cnt_nx  = cnt_r + 32'd1;
                    stop_nx = stop_r | stop_s;
                    if (cnt_r == gap_last_s) begin
                        state_nx = ST_ANOD;
                    end else begin
                        state_nx = ST_GAP;
                    end
                end
                ST_ANOD: begin
                    // A started pulse always finishes its anodic phase; a stop
                    // seen anywhere in the pulse takes effect afterwards.
                    drop_nx = trig[k];
                    stop_nx = stop_r | stop_s;
                    if ((cnt_r == anod_last_s) && (stop_r || stop_s)) begin
                        state_nx = ST_COOL;
                        cnt_nx   = 32'd0;
                    end else if (cnt_r == anod_last_s) begin
                        state_nx = ST_REST;
                        cnt_nx   = cnt_r + 32'd1;
                    end else begin
                        state_nx = ST_ANOD;
                        cnt_nx   = cnt_r + 32'd1;
                    end
                end
                ST_REST: begin
                    drop_nx = trig[k];
                    if (stop_s) begin
                        state_nx = ST_COOL;
                        cnt_nx   = 32'd0;
                    end else if (cnt_r == PERIOD_L - 32'd1) begin
                        cnt_nx = 32'd0;
                        if (slot_r == LAST_SLOT) begin
                            state_nx = ST_COOL;
                        end else begin
                            slot_nx = slot_r + SLOT_W'(1);
                            if (t_wave_inhibit) begin
                                state_nx = ST_REST;
                                skip_nx  = 1'b1;
                            end else begin
                                state_nx = ST_CATH;
                            end
                        end
                    end else begin
                        cnt_nx = cnt_r + 32'd1;
                    end
                end
                ST_COOL: begin
                    drop_nx = trig[k];
                    if (cnt_r == REFRACT_L - 32'd1) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = 32'd0;
                    end else begin
                        cnt_nx = cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 32'd0;
                end
            endcase
        end

        // Leaky bucket: charges while either phase drives, drains otherwise.
        always_comb begin
            bucket_nx = bucket_r;
            if (cath_r || anod_r) begin
                bucket_nx = (bucket_r == 32'hFFFF_FFFF) ? bucket_r : bucket_r + 32'd1;
            end else begin
                bucket_nx = (bucket_r == 32'd0) ? 32'd0 : bucket_r - 32'd1;
            end
        end

        // State, counters and registered outputs; reset drops drive at once.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r  <= ST_IDLE;
                cnt_r    <= 32'd0;
                bucket_r <= 32'd0;
                slot_r   <= '0;
                w_r      <= 8'd0;
                stop_r   <= 1'b0;
                cath_r   <= 1'b0;
                anod_r   <= 1'b0;
                busy_r   <= 1'b0;
                drop_r   <= 1'b0;
                skip_r   <= 1'b0;
            end else begin
                state_r  <= state_nx;
                cnt_r    <= cnt_nx;
                bucket_r <= bucket_nx;
                slot_r   <= slot_nx;
                w_r      <= w_nx;
                stop_r   <= stop_nx;
                cath_r   <= (state_nx == ST_CATH);
                anod_r   <= (state_nx == ST_ANOD);
                busy_r   <= (state_nx != ST_IDLE);
                drop_r   <= drop_nx;
                skip_r   <= skip_nx;
            end
        end

        assign stim_cath[k]     = cath_r;
        assign stim_anod[k]     = anod_r;
        assign burst_busy[k]    = busy_r;
        assign safety_active[k] = safety_s;
        assign trig_drop[k]     = drop_r;
        assign pulse_skip[k]    = skip_r;
    end

endmodule

// File: tb/tb_boreal_tvns_multichan_stim.sv
// Testbench for boreal_tvns_multichan_stim with a time-offset reference model:
// expected drive is computed from (cycle - burst start) by division/modulo.
module tb_boreal_tvns_multichan_stim;

    localparam int N = 2, C = 1, P = 100, B = 3, IPG = 2, BUD = 50, R = 20, ADM = 5, IMAX = 48;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     trig;
    logic [8*N-1:0]   intensity;
    logic             t_wave_inhibit, ad_guard_active, abort;
    logic [N-1:0]     stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip;

    int vectors = 0;
    int miscompares = 0;

    // model state: mode 0 idle, 1 burst, 2 refractory
    int m_mode[N], m_start[N], m_w[N], m_cool0[N], m_bucket[N];
    bit m_pend[N], m_drop[N];
    bit m_skip[N][B];
    int m_now;

    logic [6*N-1:0] got, want;

    boreal_tvns_multichan_stim #(
        .N_CH(N), .CYC_PER_US(C), .PERIOD_CYC(P), .BURST_PULSES(B), .IPG_CYC(IPG),
        .BUDGET_CYC(BUD), .REFRACT_CYC(R), .AD_MAX_INT(ADM), .INT_MAX(IMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .intensity(intensity),
        .t_wave_inhibit(t_wave_inhibit), .ad_guard_active(ad_guard_active), .abort(abort),
        .stim_cath(stim_cath), .stim_anod(stim_anod), .burst_busy(burst_busy),
        .safety_active(safety_active), .trig_drop(trig_drop), .pulse_skip(pulse_skip)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0; m_start[c] = 0; m_w[c] = 0; m_cool0[c] = 0;
            m_bucket[c] = 0; m_pend[c] = 1'b0; m_drop[c] = 1'b0;
            for (int s = 0; s < B; s++) m_skip[c][s] = 1'b0;
        end
        m_now = 0;
    endfunction

    function automatic int slot_of(int c); return (m_now - m_start[c]) / P; endfunction
    function automatic int pos_of(int c);  return (m_now - m_start[c]) % P; endfunction

    function automatic bit exp_cath(int c);
        if (m_mode[c] != 1) return 1'b0;
        if (m_skip[c][slot_of(c)]) return 1'b0;
        return pos_of(c) < m_w[c] * C;
    endfunction

    function automatic bit exp_anod(int c);
        if (m_mode[c] != 1) return 1'b0;
        if (m_skip[c][slot_of(c)]) return 1'b0;
        return (pos_of(c) >= m_w[c] * C + IPG) && (pos_of(c) < 2 * m_w[c] * C + IPG);
    endfunction

    function automatic bit exp_pskip(int c);
        if (m_mode[c] != 1) return 1'b0;
        return m_skip[c][slot_of(c)] && (pos_of(c) == 0);
    endfunction

    function automatic logic [6*N-1:0] model_out();
        logic [N-1:0] ca, an, bu, sa, dr, sk;
        for (int c = 0; c < N; c++) begin
            ca[c] = exp_cath(c); an[c] = exp_anod(c); bu[c] = (m_mode[c] != 0);
            sa[c] = (m_bucket[c] >= BUD); dr[c] = m_drop[c]; sk[c] = exp_pskip(c);
        end
        return {ca, an, bu, sa, dr, sk};
    endfunction

    // Advance the model by one cycle using the inputs applied in this cycle.
    function automatic void model_step();
        for (int c = 0; c < N; c++) begin
            bit act, stop, nd;
            int wc, lim, slot, pos, pend_end;
            act  = exp_cath(c) || exp_anod(c);
            stop = abort || (m_bucket[c] >= BUD);
            nd   = 1'b0;
            if (m_mode[c] == 0) begin
                if (trig[c]) begin
                    wc  = int'(intensity[8*c +: 8]);
                    lim = ad_guard_active ? ADM : IMAX;
                    if (wc > lim) wc = lim;
                    if (!stop && wc != 0) begin
                        m_mode[c] = 1; m_start[c] = m_now + 1; m_w[c] = wc; m_pend[c] = 1'b0;
                        for (int s = 0; s < B; s++) m_skip[c][s] = 1'b0;
                        m_skip[c][0] = t_wave_inhibit;
                    end else begin
                        nd = 1'b1;
                    end
                end
            end else if (m_mode[c] == 1) begin
                nd = trig[c];
                slot = slot_of(c); pos = pos_of(c);
                pend_end = 2 * m_w[c] * C + IPG;
                if (!m_skip[c][slot] && pos < pend_end) begin
                    if (stop) m_pend[c] = 1'b1;
                    if (pos == pend_end - 1 && m_pend[c]) begin
                        m_mode[c] = 2; m_cool0[c] = m_now + 1;
                    end
                end else if (stop) begin
                    m_mode[c] = 2; m_cool0[c] = m_now + 1;
                end else if (pos == P - 1) begin
                    if (slot == B - 1) begin
                        m_mode[c] = 2; m_cool0[c] = m_now + 1;
                    end else begin
                        m_skip[c][slot + 1] = t_wave_inhibit;
                    end
                end
            end else begin
                nd = trig[c];
                if (m_now - m_cool0[c] == R - 1) m_mode[c] = 0;
            end
            m_drop[c] = nd;
            if (act) m_bucket[c]++;
            else if (m_bucket[c] > 0) m_bucket[c]--;
        end
        m_now++;
    endfunction

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        trig = '0; intensity = '0; t_wave_inhibit = 1'b0; ad_guard_active = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
        vectors++;
        if (got !== '0) begin
            miscompares++; $display("FAIL reset_outputs got=%h want=0", got);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int first_cath = -1, first_anod = -1, busy_low = -1, ncath = 0;
        for (int i = 0; i < 330; i++) begin
            idle_inputs();
            if (i == 0) begin trig = 2'b01; intensity[7:0] = 8'd10; end
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL basic cyc=%0d got=%h want=%h", i, got, want);
            end
            if (stim_cath[0]) begin ncath++; if (first_cath < 0) first_cath = i; end
            if (stim_anod[0] && first_anod < 0) first_anod = i;
            if (i > 0 && !burst_busy[0] && busy_low < 0) busy_low = i;
            advance();
        end
        vectors += 4;
        if (first_cath !== 1)  begin miscompares++; $display("FAIL basic_cath_rise got=%0d want=1", first_cath); end
        if (first_anod !== 13) begin miscompares++; $display("FAIL basic_anod_rise got=%0d want=13", first_anod); end
        if (ncath !== 30)      begin miscompares++; $display("FAIL basic_cath_cycles got=%0d want=30", ncath); end
        if (busy_low !== 321)  begin miscompares++; $display("FAIL basic_busy_fall got=%0d want=321", busy_low); end
    endtask

    task automatic test_inhibit();
        int slot1_cath = 0;
        logic skip_101 = 1'b0, cath_201 = 1'b0;
        for (int i = 0; i < 330; i++) begin
            idle_inputs();
            if (i == 0) begin trig = 2'b01; intensity[7:0] = 8'd10; end
            // presented in the cycle whose closing edge starts slot 1
            if (i == 100) t_wave_inhibit = 1'b1;
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL inhibit cyc=%0d got=%h want=%h", i, got, want);
            end
            if (i >= 101 && i <= 200 && (stim_cath[0] || stim_anod[0])) slot1_cath++;
            if (i == 101) skip_101 = pulse_skip[0];
            if (i == 201) cath_201 = stim_cath[0];
            advance();
        end
        vectors += 3;
        if (slot1_cath !== 0)  begin miscompares++; $display("FAIL inhibit_slot1_drive got=%0d want=0", slot1_cath); end
        if (skip_101 !== 1'b1) begin miscompares++; $display("FAIL inhibit_skip_strobe got=%b want=1", skip_101); end
        if (cath_201 !== 1'b1) begin miscompares++; $display("FAIL inhibit_slot2_cath got=%b want=1", cath_201); end
    endtask

    task automatic test_safety_trip();
        int ncath = 0, nanod = 0, last_anod = -1;
        logic tripped = 1'b0, drop_104 = 1'b0;
        for (int i = 0; i < 190; i++) begin
            idle_inputs();
            if (i == 0)   begin trig = 2'b01; intensity[7:0] = 8'd40; end
            if (i == 103) begin trig = 2'b01; intensity[7:0] = 8'd10; end
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL safety cyc=%0d got=%h want=%h", i, got, want);
            end
            if (stim_cath[0]) ncath++;
            if (stim_anod[0]) begin nanod++; last_anod = i; end
            if (safety_active[0] && stim_anod[0]) tripped = 1'b1;
            if (i == 104) drop_104 = trig_drop[0];
            advance();
        end
        vectors += 5;
        if (ncath !== 40)      begin miscompares++; $display("FAIL safety_cath_cycles got=%0d want=40", ncath); end
        if (nanod !== 40)      begin miscompares++; $display("FAIL safety_anod_cycles got=%0d want=40", nanod); end
        if (last_anod !== 82)  begin miscompares++; $display("FAIL safety_anod_end got=%0d want=82", last_anod); end
        if (tripped !== 1'b1)  begin miscompares++; $display("FAIL safety_trip_in_anod got=%b want=1", tripped); end
        if (drop_104 !== 1'b1) begin miscompares++; $display("FAIL safety_trig_drop got=%b want=1", drop_104); end
    endtask

    task automatic test_ad_guard();
        int ncath = 0, nanod = 0;
        logic drop_323 = 1'b0, drive_late = 1'b0;
        for (int i = 0; i < 330; i++) begin
            idle_inputs();
            ad_guard_active = 1'b1;
            if (i == 0)   begin trig = 2'b01; intensity[7:0] = 8'd10; end
            if (i == 322) begin trig = 2'b01; intensity[7:0] = 8'd0; end
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL ad_guard cyc=%0d got=%h want=%h", i, got, want);
            end
            if (stim_cath[0]) ncath++;
            if (stim_anod[0]) nanod++;
            if (i == 323) drop_323 = trig_drop[0];
            if (i > 322 && (stim_cath[0] || burst_busy[0])) drive_late = 1'b1;
            advance();
        end
        vectors += 4;
        if (ncath !== 15)        begin miscompares++; $display("FAIL adg_cath_cycles got=%0d want=15", ncath); end
        if (nanod !== 15)        begin miscompares++; $display("FAIL adg_anod_cycles got=%0d want=15", nanod); end
        if (drop_323 !== 1'b1)   begin miscompares++; $display("FAIL adg_zero_drop got=%b want=1", drop_323); end
        if (drive_late !== 1'b0) begin miscompares++; $display("FAIL adg_zero_nodrive got=%b want=0", drive_late); end
    endtask

    task automatic test_abort_dual();
        int nanod = 0, busy_low = -1;
        logic [N-1:0] cath_51 = '0;
        for (int i = 0; i < 380; i++) begin
            idle_inputs();
            if (i == 0)  begin trig = 2'b01; intensity[7:0] = 8'd10; end
            if (i == 11) abort = 1'b1;
            if (i == 50) begin trig = 2'b11; intensity = {8'd12, 8'd7}; end
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL abort_dual cyc=%0d got=%h want=%h", i, got, want);
            end
            if (i < 50 && stim_anod[0]) nanod++;
            if (i > 0 && i < 50 && !burst_busy[0] && busy_low < 0) busy_low = i;
            if (i == 51) cath_51 = stim_cath;
            advance();
        end
        vectors += 3;
        if (nanod !== 10)      begin miscompares++; $display("FAIL abort_anod_cycles got=%0d want=10", nanod); end
        if (busy_low !== 43)   begin miscompares++; $display("FAIL abort_busy_fall got=%0d want=43", busy_low); end
        if (cath_51 !== 2'b11) begin miscompares++; $display("FAIL dual_start got=%b want=11", cath_51); end
    endtask

    task automatic test_reset_mid();
        int first_cath = -1;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i == 0) begin trig = 2'b01; intensity[7:0] = 8'd20; end
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", i, got, want);
            end
            advance();
        end
        // mid-cycle, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
        vectors++;
        if (got !== '0) begin
            miscompares++; $display("FAIL async_reset got=%h want=0", got);
        end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 335; i++) begin
            idle_inputs();
            if (i == 0) begin trig = 2'b01; intensity[7:0] = 8'd8; end
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", i, got, want);
            end
            if (stim_cath[0] && first_cath < 0) first_cath = i;
            advance();
        end
        vectors++;
        if (first_cath !== 1) begin miscompares++; $display("FAIL reset_retrig got=%0d want=1", first_cath); end
    endtask

    task automatic test_random();
        logic adg = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            for (int c = 0; c < N; c++) begin
                trig[c] = ($urandom_range(0, 39) == 0);
                intensity[8*c +: 8] = 8'($urandom_range(0, 60));
            end
            t_wave_inhibit = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) adg = ~adg;
            ad_guard_active = adg;
            abort = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            got = {stim_cath, stim_anod, burst_busy, safety_active, trig_drop, pulse_skip};
            want = model_out(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL random cyc=%0d got=%h want=%h", i, got, want);
            end
            if ((stim_cath & stim_anod) !== '0) begin
                miscompares++; $display("FAIL random_overlap cyc=%0d got=%b want=0", i, stim_cath & stim_anod);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inhibit();
        test_safety_trip();
        test_ad_guard();
        test_abort_dual();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
